// File: rtl/spi_master_ctrl_if.sv
// Host-side command/readback bundle for spi_master_ctrl.
// The controller takes the slave modport; the host sequencer takes master.
interface spi_master_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_data;
  logic       busy;
  logic       rd_valid;
  logic [7:0] rd_data;

  modport master (
    output cmd_valid, cmd_type, cmd_data,
    input  cmd_ready, busy, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_data,
    output cmd_ready, busy, rd_valid, rd_data
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI frame generator for the spi_wrapper slave; all outputs registered.
// Optional SPI_MASTER_AUTO_RD_EN: a type-10 frame auto-issues a type-11 frame.
module spi_master_ctrl #(
  parameter int MISO_WAIT  = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  spi_master_ctrl_if.slave host,
  output logic ss_n,
  output logic MOSI,
  input  logic MISO
);

  typedef enum logic [2:0] {
    IDLE, SEL, SHIFT, TURN, RECV, GAP
  } state_t;

  localparam logic [3:0] TURN_LAST = 4'(MISO_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [9:0] sr, sr_d;
  logic [1:0] typ, typ_d;
  logic [7:0] rx, rx_d;
  logic [7:0] rd_q, rd_d;
  logic       rdv_q, rdv_d;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;
  logic       accept;
`ifdef SPI_MASTER_AUTO_RD_EN
  logic       auto_q, auto_d;
`endif

  assign accept = host.cmd_valid && rdy_q;

  always_comb begin
    state_d = state;
    sr_d    = sr;
    typ_d   = typ;
    rx_d    = rx;
    rd_d    = rd_q;
    rdv_d   = 1'b0;
    mosi_d  = 1'b0;
`ifdef SPI_MASTER_AUTO_RD_EN
    auto_d  = auto_q;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = SEL;
          sr_d    = {host.cmd_type, host.cmd_data};
          typ_d   = host.cmd_type;
          mosi_d  = host.cmd_type[1];
`ifdef SPI_MASTER_AUTO_RD_EN
          auto_d  = (host.cmd_type == 2'b10);
`endif
        end
      end
      SEL: begin
        state_d = SHIFT;
        mosi_d  = sr[9];
        sr_d    = {sr[8:0], 1'b0};
      end
      SHIFT: begin
        if (cnt == 4'd9) begin
          state_d = (typ == 2'b11) ? TURN : GAP;
        end else begin
          mosi_d = sr[9];
          sr_d   = {sr[8:0], 1'b0};
        end
      end
      TURN: begin
        if (cnt == TURN_LAST) state_d = RECV;
      end
      RECV: begin
        rx_d = {rx[6:0], MISO};
        if (cnt == 4'd7) begin
          state_d = GAP;
          rd_d    = rx_d;
          rdv_d   = 1'b1;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
`ifdef SPI_MASTER_AUTO_RD_EN
          if (auto_q) begin
            state_d = SEL;
            sr_d    = {2'b11, 8'h00};
            typ_d   = 2'b11;
            mosi_d  = 1'b1;
            auto_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Per-state counter restarts on every state change
    if (state_d != state || state == IDLE) cnt_d = '0;
    else cnt_d = cnt + 4'd1;
    ss_d   = (state_d == IDLE) || (state_d == GAP);
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      typ    <= '0;
      rx     <= '0;
      rd_q   <= '0;
      rdv_q  <= 1'b0;
      ss_q   <= 1'b1;
      mosi_q <= 1'b0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      sr     <= sr_d;
      typ    <= typ_d;
      rx     <= rx_d;
      rd_q   <= rd_d;
      rdv_q  <= rdv_d;
      ss_q   <= ss_d;
      mosi_q <= mosi_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
    end
  end

`ifdef SPI_MASTER_AUTO_RD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_q <= 1'b0;
    else auto_q <= auto_d;
  end
`endif

  assign ss_n           = ss_q;
  assign MOSI           = mosi_q;
  assign host.cmd_ready = rdy_q;
  assign host.busy      = busy_q;
  assign host.rd_valid  = rdv_q;
  assign host.rd_data   = rd_q;

endmodule
